// File: rtl/router_fsm_np.sv
// Control FSM for the N-output packet router: header decode, load sequencing, FIFO-full stalls, packet drop.
// Optional wait-timeout drop path is compiled in when ROUTER_FSM_TIMEOUT_EN is defined.
module router_fsm_np #(
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 packet_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_packet_valid,
  output logic                 write_enb_reg,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] dest_sel,
  output logic                 pkt_drop
);

  localparam int unsigned NUM_ADDR = 1 << ADDR_W;

  // Elaboration-time parameter sanity checks.
  if (NUM_PORTS < 2 || NUM_PORTS > NUM_ADDR) begin : g_bad_ports
    $error("router_fsm_np: NUM_PORTS out of range");
  end
  if (WAIT_LIMIT < 1) begin : g_bad_limit
    $error("router_fsm_np: WAIT_LIMIT must be at least 1");
  end

  typedef enum logic [3:0] {
    S_DA   = 4'd0,
    S_WTE  = 4'd1,
    S_LFD  = 4'd2,
    S_LD   = 4'd3,
    S_FFS  = 4'd4,
    S_LAF  = 4'd5,
    S_LP   = 4'd6,
    S_CPE  = 4'd7,
    S_DROP = 4'd8
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [NUM_PORTS-1:0]   dest_sel_q, dest_sel_d;

  logic write_enb_q, detect_add_q, lfd_q, ld_q, laf_q, full_q, rst_int_q, busy_q, drop_q;
  logic write_enb_d, detect_add_d, lfd_d, ld_d, laf_d, full_d, rst_int_d, busy_d, drop_d;

  // Zero-extended flag vectors so any ADDR_W-wide index is in range.
  logic [NUM_ADDR-1:0] empty_ext;
  logic [NUM_ADDR-1:0] srst_ext;

  assign empty_ext = NUM_ADDR'(fifo_empty);
  assign srst_ext  = NUM_ADDR'(soft_reset);

`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam int unsigned CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             wait_expired;

  // Counts cycles spent in WTE; zero on every other state so WTE entry starts clean.
  assign wait_cnt_d   = (state_q == S_WTE) ? wait_cnt_q + CNT_W'(1) : '0;
  assign wait_expired = (wait_cnt_q == CNT_W'(WAIT_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  // State, latched address/select and registered decodes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_DA;
      addr_q       <= '0;
      dest_sel_q   <= '0;
      write_enb_q  <= 1'b0;
      detect_add_q <= 1'b1;
      lfd_q        <= 1'b0;
      ld_q         <= 1'b0;
      laf_q        <= 1'b0;
      full_q       <= 1'b0;
      rst_int_q    <= 1'b0;
      busy_q       <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      dest_sel_q   <= dest_sel_d;
      write_enb_q  <= write_enb_d;
      detect_add_q <= detect_add_d;
      lfd_q        <= lfd_d;
      ld_q         <= ld_d;
      laf_q        <= laf_d;
      full_q       <= full_d;
      rst_int_q    <= rst_int_d;
      busy_q       <= busy_d;
      drop_q       <= drop_d;
    end
  end

  // Next-state logic; output decodes come from the next state so they land with the state register.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    dest_sel_d = dest_sel_q;

    unique case (state_q)
      S_DA: begin
        if (packet_valid) begin
          addr_d     = data_in;
          dest_sel_d = NUM_PORTS'(1) << data_in;
          if (32'(data_in) >= NUM_PORTS) begin
            state_d = S_DROP;
          end else if (empty_ext[data_in]) begin
            state_d = S_LFD;
          end else begin
            state_d = S_WTE;
          end
        end
      end
      S_WTE: begin
        if (empty_ext[addr_q]) begin
          state_d = S_LFD;
        end
`ifdef ROUTER_FSM_TIMEOUT_EN
        else if (wait_expired) begin
          state_d = S_DROP;
        end
`endif
      end
      S_LFD: state_d = S_LD;
      S_LD: begin
        if (fifo_full) begin
          state_d = S_FFS;
        end else if (!packet_valid) begin
          state_d = S_LP;
        end
      end
      S_FFS: begin
        if (!fifo_full) begin
          state_d = S_LAF;
        end
      end
      S_LAF: begin
        if (parity_done) begin
          state_d = S_DA;
        end else if (low_packet_valid) begin
          state_d = S_LP;
        end else begin
          state_d = S_LD;
        end
      end
      S_LP:  state_d = S_CPE;
      S_CPE: state_d = fifo_full ? S_FFS : S_DA;
      S_DROP: begin
        if (!packet_valid) begin
          state_d = S_DA;
        end
      end
      default: state_d = S_DA;
    endcase

    // Read-side soft reset of the selected FIFO aborts the packet.
    if (state_q != S_DA && state_q != S_DROP && srst_ext[addr_q]) begin
      state_d = S_DA;
    end

    detect_add_d = (state_d == S_DA);
    lfd_d        = (state_d == S_LFD);
    ld_d         = (state_d == S_LD);
    laf_d        = (state_d == S_LAF);
    full_d       = (state_d == S_FFS);
    rst_int_d    = (state_d == S_CPE);
    drop_d       = (state_d == S_DROP);
    write_enb_d  = (state_d == S_LD) || (state_d == S_LP) || (state_d == S_LAF);
    busy_d       = (state_d == S_LFD) || (state_d == S_FFS) || (state_d == S_LAF) ||
                   (state_d == S_LP)  || (state_d == S_CPE) || (state_d == S_WTE);
  end

  assign write_enb_reg = write_enb_q;
  assign detect_add    = detect_add_q;
  assign lfd_state     = lfd_q;
  assign ld_state      = ld_q;
  assign laf_state     = laf_q;
  assign full_state    = full_q;
  assign rst_int_reg   = rst_int_q;
  assign busy          = busy_q;
  assign dest_sel      = dest_sel_q;
  assign pkt_drop      = drop_q;

endmodule

// File: doc/router_fsm_np.md
# router_fsm_np

Parametrised control FSM for the N-output packet router, the next generation of the fixed 1x3 router controller. It sits between the input register/parity block and the N destination FIFOs. From the packet header it decodes the destination port, sequences header/payload/parity loading, and handles FIFO-full stalls. New over the 3-port controller:
- invalid-address and wait-timeout packet drop
- a latched one-hot destination select.

## Interface
Parameters:
- NUM_PORTS, 3: number of destination FIFOs; legal range 2..2**ADDR_W.
- ADDR_W, 2: width of the header address field.
- WAIT_LIMIT, 16: maximum cycles spent waiting for a busy destination FIFO to drain (timeout build only); must be ≥1.

Ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  reset; synchronous, active-low.
- packet_valid  in  1  packet in progress on input bus.
- data_in  in  ADDR_W  header address field, sampled in DECODE_ADDRESS.
- fifo_full  in  1  full flag of the currently selected FIFO (muxed externally by dest_sel).
- fifo_empty  in  NUM_PORTS  per-FIFO empty flags.
- soft_reset  in  NUM_PORTS  per-FIFO soft reset from read-side timeout.
- parity_done  in  1  parity byte captured by register block.
- low_packet_valid  in  1  packet_valid fell while FIFO was full.
- write_enb_reg  out  1  FIFO write enable.
- detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  out  1 each  state decodes.
- busy  out  1  stall upstream source.
- dest_sel  out  NUM_PORTS  one-hot latched destination.
- pkt_drop  out  1  packet being discarded.

## Operation
- States: DECODE_ADDRESS (DA), WAIT_TILL_EMPTY (WTE), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE), DROP.
- DA:
  - if packet_valid && data_in ≥ NUM_PORTS → DROP.
  - elif packet_valid && fifo_empty[data_in] → LFD.
  - elif packet_valid → WTE.
  - else stay in DA.
  - On any exit, data_in is latched into addr_q; dest_sel = 1<<addr_q, held until the next DA exit.
- WTE: fifo_empty[addr_q] → LFD. Timeout build: after WAIT_LIMIT cycles in WTE without that flag → DROP.
- LFD → LD unconditionally.
- LD: fifo_full → FFS; else if !packet_valid → LP; else stay in LD.
- FFS: !fifo_full → LAF.
- LAF: parity_done → DA; else if low_packet_valid → LP; else → LD.
- LP → CPE unconditionally.
- CPE: fifo_full → FFS; else → DA.
- DROP: !packet_valid → DA; else stay in DROP.
- soft_reset[addr_q] high in any state except DA/DROP → DA next cycle, overriding all other transitions. soft_reset of other ports is ignored.
- Output decodes (Moore, from state register only):
  - detect_add=DA, lfd_state=LFD, ld_state=LD, laf_state=LAF, full_state=FFS, rst_int_reg=CPE.
  - write_enb_reg = LD|LP|LAF.
  - busy = LFD|FFS|LAF|LP|CPE|WTE.
  - pkt_drop = DROP.
- In DROP, busy=0 and write_enb_reg=0: the source streams on and bytes are discarded.

## Timing
- All transitions happen on the rising clk edge; outputs change in the same cycle as the state register.
- Reset values:
  - state=DA, so detect_add=1.
  - all other outputs 0, including dest_sel=0.
  - addr_q=0; wait counter=0.
- resetn low has top priority and is sampled only on the clock edge. Asserting it mid-packet returns the FSM to DA one edge later.
- Header to first write: DA(header sampled) → LFD → LD. write_enb_reg first high 2 cycles after header sample when the destination is empty.
- Wait counter: cleared on WTE entry and increments each WTE cycle. Exit to DROP on the edge where the count reaches WAIT_LIMIT−1 and the empty flag is still low. Empty flag rising on that same edge wins (→ LFD).
- Simultaneous fifo_full and !packet_valid in LD: FFS wins.
- soft_reset and resetn in the same cycle: resetn wins (same target state; counter also cleared).

## Configuration
- ROUTER_FSM_TIMEOUT_EN defined: wait counter present; WTE exits to DROP after WAIT_LIMIT cycles.
- Undefined: no counter; WTE waits indefinitely for fifo_empty[addr_q]; DROP is reached only on invalid address.

## Test plan
- Reset, then packet_valid=1, data_in=0, fifo_empty=3'b111 → DA,LFD,LD on consecutive edges; dest_sel=3'b001; packet_valid=0 → LP,CPE,DA.
- data_in=1, fifo_full pulsed 1 cycle in LD, low_packet_valid=1 → LD,FFS,LAF,LP,CPE,DA; busy high in FFS/LAF/LP/CPE.
- data_in=2, fifo_empty=3'b011, cleared 3 cycles later → 3 cycles WTE then LFD; dest_sel=3'b100.
- data_in=3 with NUM_PORTS=3 → DROP, pkt_drop=1, write_enb_reg=0 until packet_valid=0, then DA.
- Timeout build, WAIT_LIMIT=4, fifo_empty[1] held 0 → exactly 4 cycles WTE then DROP; non-timeout build stays in WTE.
- soft_reset[1] asserted in LD for port 1 → DA next edge; soft_reset[0] in same scenario → no effect.
